// File: rtl/fft_addr_seq.sv
// fft_addr_seq: butterfly address sequencer for an in-place radix-2 FFT.
// Walks every stage/butterfly of a 2^L-point transform in DIT or DIF order,
// emitting data addresses, twiddle index and group-jump flag per beat.
module fft_addr_seq #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned STAGE_GAP  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(ADDR_WIDTH+1)-1:0] log2_n,
  input  logic                            dif,
  input  logic                            ready,
  output logic                            valid,
  output logic [ADDR_WIDTH-1:0]           addr_a,
  output logic [ADDR_WIDTH-1:0]           addr_b,
  output logic [ADDR_WIDTH-2:0]           tw_addr,
  output logic [$clog2(ADDR_WIDTH)-1:0]   stage,
  output logic                            jump,
  output logic                            last_stage_beat,
  output logic                            last,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned LW = $clog2(ADDR_WIDTH + 1);
  localparam int unsigned SW = $clog2(ADDR_WIDTH);
  localparam int unsigned KW = ADDR_WIDTH - 1;
  localparam int unsigned TW = ADDR_WIDTH - 1;
  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] s_q, s_d;
  logic [LW-1:0] l_q, l_d, l_in;
  logic          dif_q, dif_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [SW-1:0] p;
  logic [AW-1:0] kx, mask, low, a_c, b_c;
  logic [TW-1:0] tw_c;
  logic [KW-1:0] half_m1;
  logic          lsb_c, last_c, run_c;

  logic          valid_d, jump_d, lsb_d, last_d, busy_d, done_d;
  logic [AW-1:0] addr_a_d, addr_b_d;
  logic [TW-1:0] tw_d;
  logic [SW-1:0] stage_d;

  // Requested size clamped into 1..ADDR_WIDTH
  assign l_in = (log2_n == '0) ? LW'(1) :
                (log2_n > LW'(ADDR_WIDTH)) ? LW'(ADDR_WIDTH) : log2_n;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus butterfly/stage/gap counters
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    l_d     = l_q;
    dif_d   = dif_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          s_d     = '0;
          l_d     = l_in;
          dif_d   = dif;
        end
      end
      RUN: begin
        if (ready) begin
          if (last) begin
            state_d = DONE;
          end else if (last_stage_beat) begin
            k_d = '0;
            s_d = s_q + SW'(1);
            if (STAGE_GAP > 0) begin
              state_d = GAP;
              gap_d   = GW'(STAGE_GAP - 1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = RUN;
        else             gap_d   = gap_q - GW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q   <= '0;
      s_q   <= '0;
      l_q   <= '0;
      dif_q <= 1'b0;
      gap_q <= '0;
    end else begin
      k_q   <= k_d;
      s_q   <= s_d;
      l_q   <= l_d;
      dif_q <= dif_d;
      gap_q <= gap_d;
    end
  end

  // Beat fields for the upcoming cycle, derived from next k/s/L
  always_comb begin
    p       = dif_d ? (SW'(l_d) - SW'(1) - s_d) : s_d;
    kx      = AW'(k_d);
    mask    = (AW'(1) << p) - AW'(1);
    low     = kx & mask;
    a_c     = ((kx & ~mask) << 1) | low;
    b_c     = a_c | (AW'(1) << p);
    tw_c    = TW'(low << (SW'(ADDR_WIDTH - 1) - p));
    half_m1 = (KW'(1) << (l_d - LW'(1))) - KW'(1);
    lsb_c   = (k_d == half_m1);
    last_c  = lsb_c && (s_d == (SW'(l_d) - SW'(1)));
    run_c   = (state_d == RUN);

    valid_d  = run_c;
    busy_d   = run_c || (state_d == GAP);
    done_d   = (state_d == DONE);
    addr_a_d = run_c ? a_c : '0;
    addr_b_d = run_c ? b_c : '0;
    tw_d     = run_c ? tw_c : '0;
    stage_d  = run_c ? s_d : '0;
    jump_d   = run_c && (k_d != '0) && (low == '0);
    lsb_d    = run_c && lsb_c;
    last_d   = run_c && last_c;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid           <= 1'b0;
      addr_a          <= '0;
      addr_b          <= '0;
      tw_addr         <= '0;
      stage           <= '0;
      jump            <= 1'b0;
      last_stage_beat <= 1'b0;
      last            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      valid           <= valid_d;
      addr_a          <= addr_a_d;
      addr_b          <= addr_b_d;
      tw_addr         <= tw_d;
      stage           <= stage_d;
      jump            <= jump_d;
      last_stage_beat <= lsb_d;
      last            <= last_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_addr_seq.sv
// Bench for fft_addr_seq: nested-loop butterfly model, random backpressure,
// clamp limits, reset abort, and a zero-gap build.
module tb_fft_addr_seq;

  localparam int unsigned AW  = 13;
  localparam int unsigned LW  = 4;
  localparam int unsigned SW  = 4;
  localparam int unsigned GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, dif, ready;
  logic [LW-1:0] log2_n;

  logic          d_valid, d_jump, d_lsb, d_last, d_busy, d_done;
  logic [AW-1:0] d_a, d_b;
  logic [AW-2:0] d_tw;
  logic [SW-1:0] d_st;
  logic          g_valid, g_jump, g_lsb, g_last, g_busy, g_done;
  logic [AW-1:0] g_a, g_b;
  logic [AW-2:0] g_tw;
  logic [SW-1:0] g_st;

  fft_addr_seq #(.ADDR_WIDTH(AW), .STAGE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .log2_n(log2_n), .dif(dif),
    .ready(ready), .valid(d_valid), .addr_a(d_a), .addr_b(d_b),
    .tw_addr(d_tw), .stage(d_st), .jump(d_jump), .last_stage_beat(d_lsb),
    .last(d_last), .busy(d_busy), .done(d_done));

  fft_addr_seq #(.ADDR_WIDTH(AW), .STAGE_GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(start), .log2_n(log2_n), .dif(dif),
    .ready(ready), .valid(g_valid), .addr_a(g_a), .addr_b(g_b),
    .tw_addr(g_tw), .stage(g_st), .jump(g_jump), .last_stage_beat(g_lsb),
    .last(g_last), .busy(g_busy), .done(g_done));

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  typedef struct {
    int a; int b; int tw; int st; bit jump; bit lsb; bit last;
  } beat_t;
  beat_t exp_q[$];
  logic [63:0] last_beat;

  logic [63:0] obs;
  logic        ovalid, obusy, odone;

  // Observed beat of the selected instance
  always_comb begin
    if (sel) begin
      obs    = {19'd0, g_a, g_b, g_tw, g_st, g_jump, g_lsb, g_last};
      ovalid = g_valid; obusy = g_busy; odone = g_done;
    end else begin
      obs    = {19'd0, d_a, d_b, d_tw, d_st, d_jump, d_lsb, d_last};
      ovalid = d_valid; obusy = d_busy; odone = d_done;
    end
  end

  function automatic logic [63:0] pack(input int a, input int b, input int tw,
                                       input int st, input bit j, input bit l,
                                       input bit x);
    return {19'd0, 13'(a), 13'(b), 12'(tw), 4'(st), j, l, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference: enumerate butterfly groups directly for every stage
  function automatic void build(input int L, input bit d);
    beat_t e;
    int n, p, half, k;
    exp_q.delete();
    n = 1 << L;
    for (int s = 0; s < L; s++) begin
      p = d ? (L - 1 - s) : s;
      half = 1 << p;
      k = 0;
      for (int base = 0; base < n; base += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          e.a    = base + j;
          e.b    = base + j + half;
          e.tw   = j * (4096 >> p);
          e.st   = s;
          e.jump = (k != 0) && (j == 0);
          e.lsb  = (k == n / 2 - 1);
          e.last = e.lsb && (s == L - 1);
          exp_q.push_back(e);
          k++;
        end
      end
    end
  endfunction

  task automatic run(input int lreq, input bit dif_in, input bit rnd,
                     input bit hold, input int gap_exp);
    int leff, total, idx, cyc, gapc, budget;
    bit in_gap, stalled, got_done;
    logic [63:0] held;
    leff  = (lreq == 0) ? 1 : ((lreq > 13) ? 13 : lreq);
    build(leff, dif_in);
    total  = exp_q.size();
    budget = rnd ? (20 * total + 200) : (total + leff * GAP + 20);
    @(negedge clk);
    start  = 1'b1;
    log2_n = LW'(lreq);
    dif    = dif_in;
    ready  = 1'b1;
    idx = 0; cyc = 0; gapc = 0;
    in_gap = 0; stalled = 0; got_done = 0; held = '0;
    while (!got_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        log2_n = LW'($urandom);
        dif    = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) chk("start_busy", {62'd0, ovalid, obusy}, 64'd3);
      if (stalled) chk("stall", {ovalid, obs[62:0]}, {1'b1, held[62:0]});
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (odone) begin
        got_done = 1;
        start    = 1'b0;
        stalled  = 0;
        chk("beats", 64'(idx), 64'(total));
        chk("done_quiet", {62'd0, ovalid, obusy}, 64'd0);
        if (!rnd)
          chk("done_cyc", 64'(cyc),
              64'(leff * (1 << (leff - 1)) + (leff - 1) * gap_exp + 1));
      end else if (ovalid) begin
        if (in_gap) begin
          chk("gap_len", 64'(gapc), 64'(gap_exp));
          in_gap = 0;
        end
        if (idx < total) chk("beat", obs, pack(exp_q[idx].a, exp_q[idx].b,
                             exp_q[idx].tw, exp_q[idx].st, exp_q[idx].jump,
                             exp_q[idx].lsb, exp_q[idx].last));
        else chk("extra_beat", 64'(idx), 64'(total));
        last_beat = obs;
        held      = obs;
        stalled   = !ready;
        if (ready) idx++;
      end else begin
        stalled = 0;
        chk("busy_hold", {63'd0, obusy}, 64'd1);
        if (!in_gap) begin in_gap = 1; gapc = 0; end
        gapc++;
      end
    end
    start = 1'b0;
    if (!got_done) chk("timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("done_pulse", {61'd0, odone, obusy, ovalid}, 64'd0);
  endtask

  initial begin
    bit found, seen_s1, seen_done;
    rst_n = 1'b0; start = 1'b0; dif = 1'b0; ready = 1'b0; log2_n = '0;
    repeat (3) @(negedge clk);
    chk("reset_main", {obs[62:0], ovalid} | {61'd0, obusy, odone, 1'b0}, 64'd0);
    chk("reset_g0", {19'd0, g_a, g_b, g_tw, g_st, g_jump, g_lsb, g_last} |
                    {61'd0, g_valid, g_busy, g_done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", {61'd0, ovalid, obusy, odone}, 64'd0);

    run(3, 1'b0, 1'b0, 1'b0, GAP);
    run(3, 1'b1, 1'b0, 1'b0, GAP);
    run(4, 1'b0, 1'b1, 1'b0, GAP);
    run(4, 1'b1, 1'b1, 1'b0, GAP);
    run(0, 1'b0, 1'b1, 1'b0, GAP);
    chk("l0_beat", last_beat, pack(0, 1, 0, 0, 1'b0, 1'b1, 1'b1));
    run(5, 1'b1, 1'b0, 1'b1, GAP);
    run(15, 1'b0, 1'b0, 1'b0, GAP);
    chk("clamp_final", last_beat, pack(4095, 8191, 4095, 12, 1'b0, 1'b1, 1'b1));

    // Abort with reset while in the stage-1 gap
    @(negedge clk);
    start = 1'b1; log2_n = 4'd3; dif = 1'b0; ready = 1'b1;
    found = 0; seen_s1 = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (ovalid && obs[6:3] == 4'd1) seen_s1 = 1;
      if (seen_s1 && !ovalid && obusy) found = 1;
    end
    chk("find_gap", {63'd0, found}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", {obs[62:0], ovalid} | {61'd0, obusy, odone, 1'b0}, 64'd0);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (odone) seen_done = 1;
    end
    chk("no_done", {63'd0, seen_done}, 64'd0);
    chk("post_rst_idle", {62'd0, ovalid, obusy}, 64'd0);

    run(3, 1'b1, 1'b0, 1'b0, GAP);

    sel = 1'b1;
    run(3, 1'b0, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
